// File: rtl/ps2_device_emulator.sv
// ps2_device_emulator
// Device (keyboard/mouse) end of a PS/2 link. Generates the PS/2 clock,
// sends device-to-host bytes, detects host request-to-send and clocks in
// and acknowledges host-to-device commands.
//
// Ports:
//   CLOCK_50    system clock
//   reset       synchronous, active-high
//   tx_data     byte to send to host
//   tx_valid    send request; taken when tx_valid && tx_ready
//   tx_ready    emulator can accept a byte
//   tx_aborted  1-cycle pulse: host inhibited an in-flight TX
//   rx_data     last good command received from host
//   rx_data_en  1-cycle pulse: rx_data updated (parity and stop OK)
//   rx_error    1-cycle pulse: parity or stop error (ACK still sent)
//   PS2_CLK     open-drain clock, driven 0 or z
//   PS2_DAT     open-drain data, driven 0 or z
//
// Handshake: a byte is transferred on a rising CLOCK_50 edge where
// tx_valid and tx_ready are both 1; tx_data must be stable in that cycle.
module ps2_device_emulator #(
    parameter int CLK_HALF = 2000,
    parameter int IDLE_MIN = 2500,
    parameter int GAP      = 4000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_aborted,
    output logic [7:0] rx_data,
    output logic       rx_data_en,
    output logic       rx_error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int PW = $clog2(2 * CLK_HALF);
    localparam int IW = $clog2(IDLE_MIN + 1);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [PW-1:0] PH_HALF   = PW'(CLK_HALF);
    localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_HALF - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_HALF + CLK_HALF / 2);
    // Our own clock release takes a few cycles to come back through the
    // synchronizer, so early high-phase cycles cannot be read as inhibit.
    localparam logic [PW-1:0] INH_LO    = PW'(4);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_MIN);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBITED = 3'd1,
        TX        = 3'd2,
        TX_GAP    = 3'd3,
        RX        = 3'd4,
        RX_ACK    = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] phase, phase_d;
    logic [3:0]    slot, slot_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [IW-1:0] idle_cnt;
    logic [10:0]   tx_frame;
    logic [9:0]    rx_shift;
    logic          clk_meta, clk_s, dat_meta, dat_s;
    logic          clk_low_q, dat_low_q, clk_low_d, dat_low_d;
    logic          accept, abort, sample_rx, post_ok, post_err;

    // Line drives are registered so the open-drain enables never glitch.
    assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

    // Gated by clk_s so a host inhibit arriving in the same cycle is never
    // advertised as an accepting cycle.
    assign tx_ready = (state == IDLE) && (idle_cnt == IDLE_MAX) && clk_s;

    always_comb begin
        state_d   = state;
        phase_d   = phase;
        slot_d    = slot;
        gap_d     = gap_cnt;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        accept    = 1'b0;
        abort     = 1'b0;
        sample_rx = 1'b0;
        post_ok   = 1'b0;
        post_err  = 1'b0;
        case (state)
            IDLE: begin
                phase_d = '0;
                slot_d  = '0;
                gap_d   = '0;
                if (!clk_s) begin
                    state_d = INHIBITED;
                end else if (tx_valid && tx_ready) begin
                    accept  = 1'b1;
                    state_d = TX;
                end
            end
            INHIBITED: begin
                phase_d = '0;
                slot_d  = '0;
                if (clk_s) state_d = dat_s ? IDLE : RX;
            end
            TX: begin
                clk_low_d = (phase >= PH_HALF);
                dat_low_d = ~tx_frame[slot];
                if ((slot != 4'd10) && (phase >= INH_LO) && (phase < PH_HALF) && !clk_s) begin
                    abort     = 1'b1;
                    state_d   = INHIBITED;
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                end else if (phase == PH_LAST) begin
                    phase_d = '0;
                    if (slot == 4'd10) begin
                        state_d = TX_GAP;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot + 4'd1;
                    end
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            TX_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            RX: begin
                clk_low_d = (phase < PH_HALF);
                sample_rx = (phase == PH_SAMPLE);
                if (phase == PH_LAST) begin
                    phase_d = '0;
                    if (slot == 4'd9) begin
                        state_d = RX_ACK;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot + 4'd1;
                    end
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            RX_ACK: begin
                clk_low_d = (phase < PH_HALF);
                dat_low_d = 1'b1;
                if (phase == PH_LAST) begin
                    phase_d   = '0;
                    state_d   = IDLE;
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                    // rx_shift = {stop, parity, D7..D0}; odd parity over 9 bits
                    if ((^rx_shift[8:0]) && rx_shift[9]) post_ok = 1'b1;
                    else                                 post_err = 1'b1;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            slot       <= '0;
            gap_cnt    <= '0;
            idle_cnt   <= '0;
            tx_frame   <= '0;
            rx_shift   <= '0;
            clk_meta   <= 1'b1;
            clk_s      <= 1'b1;
            dat_meta   <= 1'b1;
            dat_s      <= 1'b1;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            tx_aborted <= 1'b0;
            rx_data    <= 8'h00;
            rx_data_en <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            clk_meta   <= PS2_CLK;
            clk_s      <= clk_meta;
            dat_meta   <= PS2_DAT;
            dat_s      <= dat_meta;
            state      <= state_d;
            phase      <= phase_d;
            slot       <= slot_d;
            gap_cnt    <= gap_d;
            clk_low_q  <= clk_low_d;
            dat_low_q  <= dat_low_d;
            tx_aborted <= abort;
            rx_data_en <= post_ok;
            rx_error   <= post_err;
            if (clk_s && dat_s) begin
                if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
            // Frame order on the wire (LSB first): start, D0..D7, odd parity, stop
            if (accept) tx_frame <= {1'b1, ~(^tx_data), tx_data, 1'b0};
            if (sample_rx) rx_shift <= {dat_s, rx_shift[9:1]};
            if (post_ok) rx_data <= rx_shift[7:0];
        end
    end

endmodule
